regfile_wr_arbiter: RTL and testbench

Shares the single write port of the CPU's 19-bit register file between several writeback sources: ALU result, load return and the debug/init path.
- Accepts one write per cycle using a round-robin, valid/ready handshake with optional lock.
- Drives the register file's write-enable, address and data from registered outputs.
- Discards writes to R0 and counts cycles in which requesters contended.
- Sits between the execute/memory stages and the register file inside `CPU`.

---
 rtl/regfile_wr_arbiter.sv | 114 +++++++++++
 tb/tb_regfile_wr_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Outputs are registered; R0 writes are accepted and discarded.
module regfile_wr_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 19,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [CNT_W-1:0]         conflict_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_vld;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic              contend;

  // Scan from ptr, wrapping, and take the first valid requester.
  always_comb begin : grant_search
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_vld && req_valid[PW'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    if (!reset || stall) gnt_vld = 1'b0;
  end

  always_comb begin : contention
    int nv;
    nv = 0;
    for (int k = 0; k < NREQ; k++) begin
      nv = nv + int'(req_valid[k]);
    end
    contend = !stall && (nv >= 2);
  end

  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  assign g_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign g_data = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

  always_comb begin
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    if (gnt_vld) begin
      if (req_lock[gnt_idx]) begin
        ptr_d = gnt_idx;
      end else if (gnt_idx == PW'(NREQ-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + 1'b1;
      end
      if (g_addr != '0) begin
        we_d    = 1'b1;
        waddr_d = g_addr;
        wdata_d = g_data;
      end
    end
    if (contend && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rf_we        = we_q;
  assign rf_waddr     = waddr_q;
  assign rf_wdata     = wdata_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: queue-free behavioural model plus
// directed vectors; a CNT_W=2 copy exercises counter saturation.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  valid = 3'b111;
  logic [2:0]  lock = 3'b000;
  logic [2:0]  a [3];
  logic [18:0] d [3];
  logic [8:0]  req_addr;
  logic [56:0] req_data;

  logic [2:0]  ready, ready2;
  logic        we, we2;
  logic [2:0]  wa, wa2;
  logic [18:0] wd, wd2;
  logic [7:0]  cnt;
  logic [1:0]  cnt2;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // model state
  int          m_ptr = 0;
  logic        m_we = 0;
  logic [2:0]  m_wa = 0;
  logic [18:0] m_wd = 0;
  int          m_cnt = 0;

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.NREQ(3), .DATA_W(19), .ADDR_W(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .req_valid(valid), .req_lock(lock),
    .req_addr(req_addr), .req_data(req_data),
    .req_ready(ready), .rf_we(we), .rf_waddr(wa), .rf_wdata(wd),
    .conflict_cnt(cnt)
  );

  regfile_wr_arbiter #(.NREQ(3), .DATA_W(19), .ADDR_W(3), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall),
    .req_valid(valid), .req_lock(lock),
    .req_addr(req_addr), .req_data(req_data),
    .req_ready(ready2), .rf_we(we2), .rf_waddr(wa2), .rf_wdata(wd2),
    .conflict_cnt(cnt2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: outputs checked at every negedge, then the model advances
  // using the inputs that the next rising edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        int g;
        int exp_rdy;
        int cnt_sat;
        if (!reset) begin
          m_ptr = 0; m_we = 0; m_wa = 0; m_wd = 0; m_cnt = 0;
        end
        g = -1;
        if (reset && !stall)
          for (int k = 0; k < 3; k++)
            if (g < 0 && valid[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
        exp_rdy = (g < 0) ? 0 : (1 << g);
        cnt_sat = (m_cnt > 255) ? 255 : m_cnt;
        chk("m_ready", 32'(ready), 32'(exp_rdy));
        chk("m_ready2", 32'(ready2), 32'(exp_rdy));
        chk("m_we", 32'(we), 32'(m_we));
        chk("m_we2", 32'(we2), 32'(m_we));
        chk("m_waddr", 32'(wa), 32'(m_wa));
        chk("m_wdata", 32'(wd), 32'(m_wd));
        chk("m_cnt", 32'(cnt), 32'(cnt_sat));
        chk("m_cnt2", 32'(cnt2), 32'((m_cnt > 3) ? 3 : m_cnt));
        if (g >= 0) begin
          m_we = (a[g] != 0);
          if (a[g] != 0) begin
            m_wa = a[g];
            m_wd = d[g];
          end
          m_ptr = lock[g] ? g : (g + 1) % 3;
        end else begin
          m_we = 0;
        end
        if (reset && !stall && $countones(valid) >= 2) m_cnt++;
      end
    end
  end

  initial begin
    logic [2:0] rr [6];
    rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 3; i++) begin
      a[i] = '0;
      d[i] = '0;
    end

    // reset held with all valid
    tick;
    chk_en = 1;
    tick;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_we", 32'(we), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);

    // release with only req 1
    tick;
    reset = 1; valid = 3'b010; a[1] = 3'd2; d[1] = 19'd5;
    @(negedge clk);
    chk("rel_ready", 32'(ready), 32'h2);
    tick;
    valid = 3'b000;
    @(negedge clk);
    chk("rel_we", 32'(we), 32'h1);
    chk("rel_waddr", 32'(wa), 32'h2);
    chk("rel_wdata", 32'(wd), 32'h5);

    // bring ptr back to 0, then round robin
    tick;
    valid = 3'b100; a[2] = 3'd3; d[2] = 19'h7ABCD;
    @(negedge clk);
    a[0] = 3'd1; d[0] = 19'h00011;
    for (int i = 0; i < 6; i++) begin
      tick;
      valid = 3'b111;
      @(negedge clk);
      chk("rr_grant", 32'(ready), 32'(rr[i]));
    end
    tick;
    valid = 3'b000;
    @(negedge clk);
    chk("rr_cnt", 32'(cnt), 32'd6);
    chk("rr_cnt2_sat", 32'(cnt2), 32'd3);
    chk("rr_last_waddr", 32'(wa), 32'd3);
    chk("rr_last_wdata", 32'(wd), 32'h7ABCD);

    // lock: req0 locked 3 cycles, unlocked 4th, then req1
    a[0] = 3'd4; d[0] = 19'h12345;
    a[1] = 3'd5; d[1] = 19'h00555;
    for (int i = 0; i < 5; i++) begin
      tick;
      valid = (i < 4) ? 3'b011 : 3'b010;
      lock  = (i < 3) ? 3'b001 : 3'b000;
      @(negedge clk);
      chk("lock_grant", 32'(ready), (i < 4) ? 32'h1 : 32'h2);
    end

    // write to R0 is accepted and dropped
    tick;
    valid = 3'b100; lock = 3'b000; a[2] = 3'd0; d[2] = 19'd7;
    @(negedge clk);
    chk("r0_ready", 32'(ready), 32'h4);
    tick;
    valid = 3'b000;
    @(negedge clk);
    chk("r0_we", 32'(we), 32'h0);
    chk("r0_waddr", 32'(wa), 32'd5);
    chk("r0_wdata", 32'(wd), 32'h00555);

    // move ptr to 1, then stall with all valid
    tick;
    valid = 3'b001; a[0] = 3'd1;
    @(negedge clk);
    chk("pre_stall_ready", 32'(ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick;
      valid = 3'b111; stall = 1'b1;
      @(negedge clk);
      chk("stall_ready", 32'(ready), 32'h0);
      chk("stall_cnt", 32'(cnt), 32'd10);
      if (i > 0) chk("stall_we", 32'(we), 32'h0);
    end
    tick;
    stall = 1'b0;
    @(negedge clk);
    chk("resume_grant", 32'(ready), 32'h2);

    // saturation of the 2-bit counter, then async reset mid-burst
    tick;
    valid = 3'b000; reset = 1'b0; a[2] = 3'd3;
    tick;
    reset = 1'b1; valid = 3'b111;
    repeat (5) @(posedge clk);
    #1;
    chk("sat_cnt", 32'(cnt), 32'd5);
    chk("sat_cnt2", 32'(cnt2), 32'd3);
    @(posedge clk);
    #1;
    chk("sat_cnt2_hold", 32'(cnt2), 32'd3);
    chk("burst_we", 32'(we), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_we", 32'(we), 32'h0);
    chk("arst_waddr", 32'(wa), 32'h0);
    chk("arst_wdata", 32'(wd), 32'h0);
    chk("arst_cnt", 32'(cnt), 32'h0);
    chk("arst_cnt2", 32'(cnt2), 32'h0);
    chk("arst_ready", 32'(ready), 32'h0);
    tick;
    reset = 1'b1; valid = 3'b000;
    tick;
    tick;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
